// File: rtl/core_test_monitor_pkg.sv
// core_test_monitor_pkg: shared state encoding and halt-loop encoding for the core test monitor
package core_test_monitor_pkg;
  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    TOUT  = 3'd4
  } state_t;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [31:0] DEF_HALT_INSTR = {20'h0, 5'd0, OP_JAL};
endpackage

// File: rtl/core_test_monitor_sat_counter32.sv
// sat_counter32: 32-bit up counter with sync clear that sticks at all-ones
module sat_counter32 (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  output logic [31:0] count
);
  always_ff @(posedge clk)
    if (clr) count <= '0;
    else if (en && count != '1) count <= count + 32'd1;
endmodule

// File: rtl/core_test_monitor.sv
// core_test_monitor: core reset release, halt-loop detect and sticky verdict; MONITOR_PCHIST_EN adds a 4-deep PC history
module core_test_monitor
  import core_test_monitor_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = 4,
  parameter logic [31:0] HALT_INSTR     = DEF_HALT_INSTR,
  parameter int unsigned HALT_REPEAT    = 3,
  parameter int unsigned DRAIN_CYCLES   = 5,
  parameter logic [31:0] PASS_VALUE     = 32'd0,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         rst,
  output logic         core_rst,
  input  logic [31:0]  pc,
  input  logic [31:0]  instr,
  input  logic [31:0]  rf_a0,
  output logic         done,
  output logic         pass,
  output logic         fail,
  output logic         timeout,
  output logic [31:0]  cycle_count,
  output logic [31:0]  fetch_count,
  output logic [31:0]  halt_pc,
  output logic [31:0]  result,
  output logic [127:0] pc_hist
);
  state_t      state;
  logic [7:0]  hold_cnt;
  logic [31:0] prev_pc, rep_cnt, rep_nxt, drain_cnt;
  logic        running, moved, tout_hit, fetch_en;
  assign running  = state == RUN || state == DRAIN;
  assign moved    = pc != prev_pc;
  assign rep_nxt  = instr == HALT_INSTR ? (moved ? 32'd1 : rep_cnt + 32'd1) : 32'd0;
  assign tout_hit = running && cycle_count == TIMEOUT_CYCLES - 1;
  assign fetch_en = state == RUN && moved && !tout_hit;
  sat_counter32 u_cycles (.clk(clk), .clr(rst), .en(running && !tout_hit), .count(cycle_count));
  sat_counter32 u_fetches (.clk(clk), .clr(rst), .en(fetch_en), .count(fetch_count));
  always_ff @(posedge clk)
    if (rst) begin
      state     <= HOLD;
      core_rst  <= 1'b1;
      hold_cnt  <= '0;
      prev_pc   <= '0;
      rep_cnt   <= '0;
      drain_cnt <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      halt_pc   <= '0;
      result    <= '0;
    end else if (tout_hit) begin
      state   <= TOUT;
      done    <= 1'b1;
      timeout <= 1'b1;
    end else
      case (state)
        HOLD: begin
          hold_cnt <= hold_cnt + 8'd1;
          if (hold_cnt == 8'(RST_CYCLES - 1)) begin
            state    <= RUN;
            core_rst <= 1'b0;
          end
        end
        RUN: begin
          prev_pc <= pc;
          rep_cnt <= rep_nxt;
          if (rep_nxt == HALT_REPEAT) begin
            halt_pc <= pc;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 32'd1;
          if (drain_cnt == DRAIN_CYCLES) begin
            result <= rf_a0;
            done   <= 1'b1;
            pass   <= rf_a0 == PASS_VALUE;
            fail   <= rf_a0 != PASS_VALUE;
            state  <= DONE;
          end
        end
        default: ;
      endcase
`ifdef MONITOR_PCHIST_EN
  logic [127:0] hist;
  always_ff @(posedge clk)
    if (rst) hist <= '0;
    else if (fetch_en) hist <= {hist[95:0], pc};
  assign pc_hist = hist;
`else
  assign pc_hist = '0;
`endif
endmodule

// File: tb/tb_core_test_monitor.sv
// tb_core_test_monitor: directed and random program streams checked against a stream-level verdict model
module tb_core_test_monitor;
  localparam logic [31:0] HALT = 32'h0000006F, NOP = 32'h00000013;
  localparam int T = 50, DR = 5, HR = 3, TI = T - 1;
  logic         clk = 0, rst = 1, core_rst, done, pass, fail, timeout;
  logic [31:0]  pc = 0, instr = 0, rf_a0 = 0, cycle_count, fetch_count, halt_pc, result;
  logic [127:0] pc_hist;
  logic [31:0]  pcs [64], ins [64];
  int           n_pass = 0, n_total = 0;
  int           e_done_at, e_cyc, e_fetch;
  logic         e_tout;
  logic [31:0]  e_halt_pc;
  logic [127:0] e_hist;
  always #5 clk = ~clk;
  core_test_monitor #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .core_rst(core_rst), .pc(pc), .instr(instr), .rf_a0(rf_a0),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout), .cycle_count(cycle_count),
    .fetch_count(fetch_count), .halt_pc(halt_pc), .result(result), .pc_hist(pc_hist)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [31:0] prv(input int i);
    return i == 0 ? 32'd0 : pcs[i-1];
  endfunction
  task automatic predict();
    int k = -1, streak = 0, last;
    e_fetch = 0;
    e_hist = '0;
    for (int i = 0; i < 64 && k < 0; i++) begin
      streak = ins[i] != HALT ? 0 : pcs[i] == prv(i) ? streak + 1 : 1;
      if (streak == HR) k = i;
    end
    e_tout = k < 0 || k + DR + 1 >= TI;
    e_done_at = e_tout ? TI : k + DR + 1;
    e_cyc = e_done_at + (e_tout ? 0 : 1);
    last = (k >= 0 && k < TI) ? k : TI - 1;
    for (int i = 0; i <= last; i++)
      if (pcs[i] != prv(i)) begin
        e_fetch++;
        e_hist = {e_hist[95:0], pcs[i]};
      end
    e_halt_pc = k >= 0 ? pcs[k] : 32'd0;
  endtask
  task automatic run(input logic [31:0] a0, input int abort_at);
    int edges = 0, done_at = -1;
    logic hold_ok = 1;
    logic [2:0] e_flags;
    rst = 1; pc = 0; instr = 0; rf_a0 = a0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_rst", core_rst, 1);
    chk("rst_counts", {cycle_count, fetch_count}, 0);
    chk("rst_verdict", {done, pass, fail, timeout, halt_pc, result}, 0);
    chk("rst_hist", pc_hist, 0);
    rst = 0;
    do begin
      @(posedge clk); #1; edges++;
      if (core_rst && (done || cycle_count != 0 || fetch_count != 0)) hold_ok = 0;
    end while (core_rst && edges < 10);
    chk("core_rst_release", edges, 4);
    chk("hold_quiet", hold_ok, 1);
    predict();
    for (int i = 0; i < 64 && done_at < 0; i++) begin
      pc = pcs[i]; instr = ins[i];
      if (i == abort_at) rst = 1;
      @(posedge clk); #1;
      if (i == abort_at) begin
        chk("abort_core_rst", core_rst, 1);
        chk("abort_counts", {cycle_count, fetch_count}, 0);
        chk("abort_verdict", {done, pass, fail, timeout}, 0);
        return;
      end
      if (done) done_at = i;
    end
    e_flags = e_tout ? 3'b001 : (a0 == 0 ? 3'b100 : 3'b010);
    chk("done_cycle", done_at, e_done_at);
    chk("done", done, 1);
    chk("verdict", {pass, fail, timeout}, e_flags);
    chk("cycle_count", cycle_count, e_cyc);
    chk("fetch_count", fetch_count, e_fetch);
    if (!e_tout) begin
      chk("halt_pc", halt_pc, e_halt_pc);
      chk("result", result, a0);
    end
`ifdef MONITOR_PCHIST_EN
    chk("pc_hist", pc_hist, e_hist);
`else
    chk("pc_hist", pc_hist, 0);
`endif
    repeat (3) begin
      pc = $urandom; instr = HALT; rf_a0 = $urandom;
      @(posedge clk); #1;
    end
    chk("sticky_flags", {done, pass, fail, timeout, core_rst}, {1'b1, e_flags, 1'b0});
    chk("sticky_counts", {cycle_count, fetch_count}, {e_cyc, e_fetch});
    if (!e_tout) chk("sticky_result", result, a0);
  endtask
  initial begin
    logic [31:0] p;
    int h;
    for (int i = 0; i < 64; i++) begin
      pcs[i] = i < 3 ? 32'(4 * i) : 32'hC;
      ins[i] = i < 3 ? NOP : HALT;
    end
    run(32'd0, -1);
    run(32'd5, -1);
    run(32'd0, 7);
    run(32'd0, -1);
    for (int i = 0; i < 64; i++) begin
      pcs[i] = i < 2 ? 32'(4 * i) : 32'h8;
      ins[i] = i < 6 ? NOP : HALT;
    end
    run(32'd0, -1);
    for (int i = 0; i < 64; i++) begin
      pcs[i] = 32'(4 * i);
      ins[i] = NOP;
    end
    run(32'd0, -1);
    for (int i = 0; i < 64; i++) begin
      pcs[i] = 32'(4 * (i < 47 ? i : 47));
      ins[i] = i < 47 ? NOP : HALT;
    end
    run(32'd0, -1);
    for (int i = 0; i < 64; i++) begin
      pcs[i] = 32'(4 * (i < 41 ? i : 41));
      ins[i] = i < 41 ? NOP : HALT;
    end
    run(32'd7, -1);
    repeat (8) begin
      p = 0;
      h = $urandom_range(4, 52);
      for (int i = 0; i < 64; i++) begin
        if (i < h) begin
          case ($urandom_range(0, 3))
            0: ;
            1, 2: p = p + 32'd4;
            default: p = $urandom & ~32'd3;
          endcase
          ins[i] = $urandom_range(0, 4) == 0 ? HALT : ($urandom_range(0, 1) == 1 ? NOP : $urandom);
        end else ins[i] = HALT;
        pcs[i] = p;
      end
      run($urandom_range(0, 1) == 1 ? 32'd0 : $urandom, -1);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
